// File: rtl/wqe_sched_wrr_if.sv
// Pop-side handshake between the WQE cache read port and the LS/BS SFIFO pair.
// The scheduler takes the slave modport; the consumer/SFIFO side takes the master modport.
interface wqe_sched_wrr_if;
    logic i_sched_rd;
    logic i_ls_empty;
    logic i_bs_empty;
    logic o_ls_ren;
    logic o_bs_ren;
    logic o_rd_val;
    logic o_rd_sel_ls;

    modport slave (
        input  i_sched_rd, i_ls_empty, i_bs_empty,
        output o_ls_ren, o_bs_ren, o_rd_val, o_rd_sel_ls
    );

    modport master (
        output i_sched_rd, i_ls_empty, i_bs_empty,
        input  o_ls_ren, o_bs_ren, o_rd_val, o_rd_sel_ls
    );
endinterface

// File: rtl/wqe_sched_wrr.sv
// Two-class weighted round-robin pop scheduler for the split WQE cache (LS = QPN 0, BS = QPN 1).
// Zero-delay grant onto the SFIFO read enables, registered mux select / valid, per-class grant counters.
module wqe_sched_wrr #(
    parameter int WGT_WIDTH  = 4,
    parameter int LS_WGT_RST = 3,
    parameter int BS_WGT_RST = 1,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    wqe_sched_wrr_if.slave       sif,
    input  logic                 i_cfg_load,
    input  logic [WGT_WIDTH-1:0] i_cfg_ls_wgt,
    input  logic [WGT_WIDTH-1:0] i_cfg_bs_wgt,
    input  logic                 i_cnt_clr,
    output logic [CNT_WIDTH-1:0] o_ls_grant_cnt,
    output logic [CNT_WIDTH-1:0] o_bs_grant_cnt,
    output logic                 o_dbg_phase_bs,
    output logic [WGT_WIDTH-1:0] o_dbg_cred
);
    typedef enum logic {PH_LS = 1'b0, PH_BS = 1'b1} phase_e;

    localparam logic [WGT_WIDTH-1:0] WGT_ONE = WGT_WIDTH'(1);
    localparam logic [WGT_WIDTH-1:0] WGT_ZERO = '0;

    phase_e               phase_q, phase_d;
    logic [WGT_WIDTH-1:0] cred_q, cred_d;
    logic [WGT_WIDTH-1:0] ls_wgt_q, bs_wgt_q;
    logic                 rd_val_q, rd_sel_ls_q;
    logic [CNT_WIDTH-1:0] ls_cnt_q, bs_cnt_q;
    logic                 gnt_ls, gnt_bs;
    logic [WGT_WIDTH-1:0] cred_dec;

    // Grant: current phase wins if non-empty, otherwise the other class is served.
    always_comb begin
        gnt_ls = 1'b0;
        gnt_bs = 1'b0;
        if (rst_n && sif.i_sched_rd) begin
            if (phase_q == PH_LS) begin
                gnt_ls = ~sif.i_ls_empty;
                gnt_bs = sif.i_ls_empty & ~sif.i_bs_empty;
            end else begin
                gnt_bs = ~sif.i_bs_empty;
                gnt_ls = sif.i_bs_empty & ~sif.i_ls_empty;
            end
        end
    end

    // A grant outside the current phase steals the round: credit restarts from that class's weight.
    always_comb begin
        phase_d  = phase_q;
        cred_d   = cred_q;
        cred_dec = cred_q - WGT_ONE;
        if (gnt_ls) begin
            cred_dec = (phase_q == PH_LS) ? (cred_q - WGT_ONE) : (ls_wgt_q - WGT_ONE);
            if (cred_dec == WGT_ZERO) begin
                phase_d = PH_BS;
                cred_d  = bs_wgt_q;
            end else begin
                phase_d = PH_LS;
                cred_d  = cred_dec;
            end
        end else if (gnt_bs) begin
            cred_dec = (phase_q == PH_BS) ? (cred_q - WGT_ONE) : (bs_wgt_q - WGT_ONE);
            if (cred_dec == WGT_ZERO) begin
                phase_d = PH_LS;
                cred_d  = ls_wgt_q;
            end else begin
                phase_d = PH_BS;
                cred_d  = cred_dec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q     <= PH_LS;
            cred_q      <= WGT_WIDTH'(LS_WGT_RST);
            ls_wgt_q    <= WGT_WIDTH'(LS_WGT_RST);
            bs_wgt_q    <= WGT_WIDTH'(BS_WGT_RST);
            rd_val_q    <= 1'b0;
            rd_sel_ls_q <= 1'b0;
            ls_cnt_q    <= '0;
            bs_cnt_q    <= '0;
        end else begin
            phase_q  <= phase_d;
            cred_q   <= cred_d;
            rd_val_q <= gnt_ls | gnt_bs;
            if (gnt_ls || gnt_bs) rd_sel_ls_q <= gnt_ls;
            // A zero weight would stall the class forever, so it is treated as one.
            if (i_cfg_load) begin
                ls_wgt_q <= (i_cfg_ls_wgt == WGT_ZERO) ? WGT_ONE : i_cfg_ls_wgt;
                bs_wgt_q <= (i_cfg_bs_wgt == WGT_ZERO) ? WGT_ONE : i_cfg_bs_wgt;
            end
            if (i_cnt_clr) begin
                ls_cnt_q <= '0;
                bs_cnt_q <= '0;
            end else begin
                if (gnt_ls) ls_cnt_q <= ls_cnt_q + CNT_WIDTH'(1);
                if (gnt_bs) bs_cnt_q <= bs_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign sif.o_ls_ren    = gnt_ls;
    assign sif.o_bs_ren    = gnt_bs;
    assign sif.o_rd_val    = rd_val_q;
    assign sif.o_rd_sel_ls = rd_sel_ls_q;
    assign o_ls_grant_cnt  = ls_cnt_q;
    assign o_bs_grant_cnt  = bs_cnt_q;
    assign o_dbg_phase_bs  = (phase_q == PH_BS);
    assign o_dbg_cred      = cred_q;
endmodule
